// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, result/destination selection,
// register-file write port, same-cycle bypass to decode and a retire counter.
module wb_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic        stall,
   input  logic        flush,
   input  logic        RegWrite,
   input  logic        MemtoReg,
   input  logic        RegDest,
   input  logic [31:0] alu_result,
   input  logic [31:0] mem_data,
   input  logic [4:0]  addr1,
   input  logic [4:0]  addr2,
   input  logic [4:0]  rd_addr_a,
   input  logic [4:0]  rd_addr_b,
   input  logic [31:0] rf_data_a,
   input  logic [31:0] rf_data_b,
   output logic [31:0] write_data,
   output logic [4:0]  write_address,
   output logic        write_enable,
   output logic [31:0] byp_data_a,
   output logic [31:0] byp_data_b,
   output logic [31:0] retire_count
);

   logic        valid_r;
   logic        reg_write_r;
   logic        mem_to_reg_r;
   logic [4:0]  dest_r;
   logic [31:0] alu_result_r;
   logic [31:0] mem_data_r;
   logic        committed_r;
   logic [31:0] retire_count_r;

   logic [31:0] write_data_s;
   logic        write_enable_s;

   // MEM/WB register and retire counter; flush outranks stall, committed
   // marks a held instruction whose single write already happened.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r        <= 1'b0;
         reg_write_r    <= 1'b0;
         mem_to_reg_r   <= 1'b0;
         dest_r         <= 5'd0;
         alu_result_r   <= 32'd0;
         mem_data_r     <= 32'd0;
         committed_r    <= 1'b0;
         retire_count_r <= 32'd0;
      end else begin
         if (write_enable_s) begin
            retire_count_r <= retire_count_r + 32'd1;
         end else begin
            retire_count_r <= retire_count_r;
         end
         if (flush) begin
            valid_r     <= 1'b0;
            committed_r <= 1'b0;
         end else if (stall) begin
            if (valid_r) begin
               committed_r <= 1'b1;
            end else begin
               committed_r <= committed_r;
            end
         end else begin
            valid_r      <= in_valid;
            reg_write_r  <= RegWrite;
            mem_to_reg_r <= MemtoReg;
            dest_r       <= RegDest ? addr2 : addr1;
            alu_result_r <= alu_result;
            mem_data_r   <= mem_data;
            committed_r  <= 1'b0;
         end
      end
   end

   // Write port and bypass muxes, combinational from the stage register.
   always_comb begin
      write_data_s   = 32'd0;
      write_enable_s = 1'b0;
      byp_data_a     = rf_data_a;
      byp_data_b     = rf_data_b;
      if (mem_to_reg_r) begin
         write_data_s = mem_data_r;
      end else begin
         write_data_s = alu_result_r;
      end
      write_enable_s = valid_r & reg_write_r & ~committed_r & (dest_r != 5'd0);
      if (write_enable_s && (rd_addr_a == dest_r)) begin
         byp_data_a = write_data_s;
      end else begin
         byp_data_a = rf_data_a;
      end
      if (write_enable_s && (rd_addr_b == dest_r)) begin
         byp_data_b = write_data_s;
      end else begin
         byp_data_b = rf_data_b;
      end
   end

   assign write_data    = write_data_s;
   assign write_address = dest_r;
   assign write_enable  = write_enable_s;
   assign retire_count  = retire_count_r;

endmodule
